// File: rtl/mips_isa_pkg.sv
// MIPS ISA constants, op codes and field-packing helpers shared by the encoder and the control decoder.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package mips_isa_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_AND  = 5'd2,
    OP_OR   = 5'd3,
    OP_SLT  = 5'd4,
    OP_SLL  = 5'd5,
    OP_SRL  = 5'd6,
    OP_ROTR = 5'd7,
    OP_ADDI = 5'd8,
    OP_ANDI = 5'd9,
    OP_ORI  = 5'd10,
    OP_SLTI = 5'd11,
    OP_XORI = 5'd12,
    OP_LW   = 5'd13,
    OP_SW   = 5'd14,
    OP_BEQ  = 5'd15,
    OP_BNE  = 5'd16,
    OP_BGTZ = 5'd17,
    OP_J    = 5'd18
  } op_e;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_SLTI  = 6'b001010;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_XORI  = 6'b001110;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BNE   = 6'b000101;
  localparam logic [5:0] OPC_BGTZ  = 6'b000111;
  localparam logic [5:0] OPC_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  // ROTR shares SRL's funct; the rs field (ROTR_RS) tells them apart.
  localparam logic [5:0] FUNCT_ROTR = 6'b000010;

  localparam logic [4:0] ROTR_RS = 5'b00001;

  localparam logic signed [31:0] IMM_S16_MIN = -32'sd32768;
  localparam logic signed [31:0] IMM_S16_MAX = 32'sd32767;
  localparam logic [31:0]        IMM_U16_MAX = 32'd65535;
  localparam logic [31:0]        IMM_J26_MAX = 32'h03FF_FFFF;

  // Raw request as captured by the first pipeline stage.
  typedef struct packed {
    logic [4:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [31:0] imm;
  } encReq_t;

  function automatic logic [31:0] rType(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                        logic [4:0] shamt, logic [5:0] funct);
    return {OPC_RTYPE, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] iType(logic [5:0] opc, logic [4:0] rs, logic [4:0] rt,
                                        logic [15:0] imm16);
    return {opc, rs, rt, imm16};
  endfunction

  function automatic logic [31:0] jType(logic [25:0] target);
    return {OPC_J, target};
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Packs a decoded op and its fields into a 32-bit MIPS word and flags illegal ops / out-of-range immediates.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is consumed.
// Ports: op/rs/rt/rd/shamt (5b each) and imm (32b) in; instr (32b) and legal (1b) out.
module instr_pack
  import mips_isa_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        legal
);

  logic fitsS16;
  logic fitsU16;
  logic fitsJ26;

  assign fitsS16 = ($signed(imm) >= IMM_S16_MIN) && ($signed(imm) <= IMM_S16_MAX);
  assign fitsU16 = imm <= IMM_U16_MAX;
  assign fitsJ26 = imm <= IMM_J26_MAX;

  always_comb begin
    instr = '0;
    legal = 1'b0;
    case (op_e'(op))
      OP_ADD:  begin instr = rType(rs, rt, rd, 5'd0, FUNCT_ADD); legal = 1'b1; end
      OP_SUB:  begin instr = rType(rs, rt, rd, 5'd0, FUNCT_SUB); legal = 1'b1; end
      OP_AND:  begin instr = rType(rs, rt, rd, 5'd0, FUNCT_AND); legal = 1'b1; end
      OP_OR:   begin instr = rType(rs, rt, rd, 5'd0, FUNCT_OR);  legal = 1'b1; end
      OP_SLT:  begin instr = rType(rs, rt, rd, 5'd0, FUNCT_SLT); legal = 1'b1; end
      // Shifts ignore the requested rs: it is 0 for plain shifts and the rotate marker for ROTR.
      OP_SLL:  begin instr = rType(5'd0, rt, rd, shamt, FUNCT_SLL);    legal = 1'b1; end
      OP_SRL:  begin instr = rType(5'd0, rt, rd, shamt, FUNCT_SRL);    legal = 1'b1; end
      OP_ROTR: begin instr = rType(ROTR_RS, rt, rd, shamt, FUNCT_ROTR); legal = 1'b1; end
      OP_ADDI: begin instr = iType(OPC_ADDI, rs, rt, imm[15:0]); legal = fitsS16; end
      OP_SLTI: begin instr = iType(OPC_SLTI, rs, rt, imm[15:0]); legal = fitsS16; end
      OP_ANDI: begin instr = iType(OPC_ANDI, rs, rt, imm[15:0]); legal = fitsU16; end
      OP_ORI:  begin instr = iType(OPC_ORI,  rs, rt, imm[15:0]); legal = fitsU16; end
      OP_XORI: begin instr = iType(OPC_XORI, rs, rt, imm[15:0]); legal = fitsU16; end
      OP_LW:   begin instr = iType(OPC_LW,   rs, rt, imm[15:0]); legal = fitsS16; end
      OP_SW:   begin instr = iType(OPC_SW,   rs, rt, imm[15:0]); legal = fitsS16; end
      OP_BEQ:  begin instr = iType(OPC_BEQ,  rs, rt, imm[15:0]); legal = fitsS16; end
      OP_BNE:  begin instr = iType(OPC_BNE,  rs, rt, imm[15:0]); legal = fitsS16; end
      // BGTZ compares rs against zero, so its rt slot is always 0.
      OP_BGTZ: begin instr = iType(OPC_BGTZ, rs, 5'd0, imm[15:0]); legal = fitsS16; end
      OP_J:    begin instr = jType(imm[25:0]); legal = fitsJ26; end
      default: begin instr = '0; legal = 1'b0; end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage MIPS instruction encoder: stage 1 holds the raw request, stage 2 the packed word plus its byte address.
// Latency: the word is valid after the edge following the accepting edge; one word per cycle at full rate.
// Backpressure: valid/ready on both sides; holds at most two requests, output stays stable while stalled.
// Ports: clk_i, rst_i (sync, active high), flush_i; in_valid_i/in_ready_o with in_op_i, in_rs_i, in_rt_i,
//        in_rd_i, in_shamt_i, in_imm_i; out_valid_o/out_ready_i with out_instr_o, out_addr_o; bad_cnt_o.
module instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [4:0]        in_op_i,
  input  logic [4:0]        in_rs_i,
  input  logic [4:0]        in_rt_i,
  input  logic [4:0]        in_rd_i,
  input  logic [4:0]        in_shamt_i,
  input  logic [31:0]       in_imm_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [31:0]       out_instr_o,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic [7:0]        bad_cnt_o
);

  encReq_t           s1Req;
  logic              s1Vld;
  logic              s2Vld;
  logic [31:0]       s2Instr;
  logic [ADDR_W-1:0] addrQ;
  logic [7:0]        badCnt;

  logic        s2Adv;
  logic        s1Adv;
  logic        inAcc;
  logic        outHs;
  logic [31:0] packInstr;
  logic        packLegal;

  assign s2Adv      = !s2Vld || out_ready_i;
  assign s1Adv      = !s1Vld || s2Adv;
  assign in_ready_o = s1Adv && !flush_i && !rst_i;
  assign inAcc      = in_valid_i && in_ready_o;
  assign outHs      = s2Vld && out_ready_i;

  instr_pack uPack (
    .op    (s1Req.op),
    .rs    (s1Req.rs),
    .rt    (s1Req.rt),
    .rd    (s1Req.rd),
    .shamt (s1Req.shamt),
    .imm   (s1Req.imm),
    .instr (packInstr),
    .legal (packLegal)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1Req   <= '0;
      s1Vld   <= 1'b0;
      s2Vld   <= 1'b0;
      s2Instr <= '0;
      addrQ   <= '0;
      badCnt  <= '0;
    end else if (flush_i) begin
      // Output handshake in this cycle is void; bad count is deliberately kept.
      s1Vld <= 1'b0;
      s2Vld <= 1'b0;
      addrQ <= '0;
    end else begin
      if (s1Adv) begin
        s1Vld <= inAcc;
        if (inAcc) begin
          s1Req <= {in_op_i, in_rs_i, in_rt_i, in_rd_i, in_shamt_i, in_imm_i};
        end
      end
      if (s2Adv) begin
        // A rejected request turns into a bubble instead of occupying stage 2.
        s2Vld <= s1Vld && packLegal;
        if (s1Vld && packLegal) begin
          s2Instr <= packInstr;
        end
      end
      if (s1Vld && s2Adv && !packLegal && (badCnt != 8'hFF)) begin
        badCnt <= badCnt + 8'd1;
      end
      if (outHs) begin
        addrQ <= addrQ + ADDR_W'(4);
      end
    end
  end

  assign out_valid_o = s2Vld;
  assign out_instr_o = s2Instr;
  assign out_addr_o  = addrQ;
  assign bad_cnt_o   = badCnt;

endmodule
